// File: rtl/seg_pkg.sv
// Shared types and constants for seven-segment display blocks.
// Latency: n/a (package only).
// Backpressure: n/a.
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low abcdefg patterns, bit 6 = a, indexed by hex value.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

endpackage

// File: rtl/seg_hex_decode.sv
// Hex nibble to active-low seven-segment pattern decoder.
// Latency: combinational, zero cycles.
// Backpressure: none.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg_n
);

    assign seg_n = HEX_SEG[nib];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with blanking gaps; SEG_LEADING_ZERO_BLANK_EN blanks leading zeros.
// Latency: all outputs registered, one cycle from state decision to pins.
// Backpressure: upd_ready low while a pending frame waits for the next frame boundary.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic                          upd_valid,
    output logic                          upd_ready,
    input  logic [4*NUM_DIGITS-1:0]       upd_data,
    output logic [6:0]                    seg_n,
    output logic [NUM_DIGITS-1:0]         an_n,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic                          frame_done
);

    localparam int IDXW    = $clog2(NUM_DIGITS);
    localparam int CNT_MAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
    localparam int CNTW    = $clog2(CNT_MAX + 1);

    localparam logic [CNTW-1:0] SHOW_LAST  = CNTW'(SCAN_DIV - 1);
    localparam logic [CNTW-1:0] BLANK_LAST = CNTW'(BLANK_CYCLES - 1);
    localparam logic [IDXW-1:0] IDX_LAST   = IDXW'(NUM_DIGITS - 1);

    state_t                        state_q, state_d;
    logic [IDXW-1:0]               idx_q, idx_d;
    logic [CNTW-1:0]               cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0][3:0]    active_q, active_d;
    logic [NUM_DIGITS-1:0][3:0]    pend_q, pend_d;
    logic                          pend_v_q, pend_v_d;
    logic                          fd_d;
    logic                          commit;
    logic [6:0]                    seg_d;
    logic [6:0]                    dec_seg;
    logic [NUM_DIGITS-1:0]         an_d;

    assign upd_ready = ~pend_v_q;
    assign digit_idx = idx_q;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        fd_d     = 1'b0;
        commit   = 1'b0;
        active_d = active_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;

        if (!enable) begin
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = BLANK;
                    cnt_d   = '0;
                end
                BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = SHOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                SHOW: begin
                    if (cnt_q == SHOW_LAST) begin
                        state_d = BLANK;
                        cnt_d   = '0;
                        if (idx_q == IDX_LAST) begin
                            idx_d  = '0;
                            fd_d   = 1'b1;
                            commit = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // A dark display has no frame to tear, so pending data may land at once.
        if (state_q == IDLE) begin
            commit = 1'b1;
        end

        if (commit && pend_v_q) begin
            active_d = pend_q;
            pend_v_d = 1'b0;
        end

        // Capture keys off the registered flag, so it never overlaps a commit.
        if (upd_valid && !pend_v_q) begin
            pend_d   = upd_data;
            pend_v_d = 1'b1;
        end
    end

    seg_hex_decode u_dec (
        .nib   (active_d[idx_d]),
        .seg_n (dec_seg)
    );

`ifdef SEG_LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] lz_blank;
    logic                  nz_seen;

    always_comb begin
        lz_blank = '0;
        nz_seen  = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            nz_seen     = nz_seen | (active_d[k] != 4'h0);
            lz_blank[k] = ~nz_seen;
        end
    end
`endif

    always_comb begin
        seg_d = SEG_BLANK;
        an_d  = '1;
        if (state_d == SHOW) begin
            an_d[idx_d] = 1'b0;
            seg_d       = dec_seg;
`ifdef SEG_LEADING_ZERO_BLANK_EN
            if (lz_blank[idx_d]) begin
                seg_d = SEG_BLANK;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            active_q   <= '0;
            pend_q     <= '0;
            pend_v_q   <= 1'b0;
            seg_n      <= SEG_BLANK;
            an_n       <= '1;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            active_q   <= active_d;
            pend_q     <= pend_d;
            pend_v_q   <= pend_v_d;
            seg_n      <= seg_d;
            an_n       <= an_d;
            frame_done <= fd_d;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl with SCAN_DIV=4, BLANK_CYCLES=2, four digits.
module tb_seg_scan_ctrl;

    localparam logic [6:0] BL = 7'h7F;
    localparam logic [6:0] P0 = 7'b0000001;
    localparam logic [6:0] P1 = 7'b1001111;
    localparam logic [6:0] P2 = 7'b0010010;
    localparam logic [6:0] P3 = 7'b0000110;
    localparam logic [6:0] P4 = 7'b1001100;
    localparam logic [6:0] P5 = 7'b0100100;
    localparam logic [6:0] PA = 7'b0001000;
    localparam logic [6:0] PF = 7'b0111000;
`ifdef SEG_LEADING_ZERO_BLANK_EN
    localparam logic [6:0] LZ = 7'h7F;
`else
    localparam logic [6:0] LZ = 7'b0000001;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        upd_valid;
    logic        upd_ready;
    logic [15:0] upd_data;
    logic [6:0]  seg_n;
    logic [3:0]  an_n;
    logic [1:0]  digit_idx;
    logic        frame_done;
    logic        probe = 1'b0;

    typedef struct {
        int         ph;
        logic [3:0] an;
        logic [6:0] seg;
        logic       fd;
        logic       rdy;
        logic [1:0] idx;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    seg_scan_ctrl #(
        .NUM_DIGITS   (4),
        .SCAN_DIV     (4),
        .BLANK_CYCLES (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .upd_valid  (upd_valid),
        .upd_ready  (upd_ready),
        .upd_data   (upd_data),
        .seg_n      (seg_n),
        .an_n       (an_n),
        .digit_idx  (digit_idx),
        .frame_done (frame_done)
    );

    // Monitor: one expectation per clock (or async probe) while the queue holds any.
    initial begin
        forever begin
            @(posedge clk or posedge probe);
            #1;
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                checks++;
                if ({an_n, seg_n, frame_done, upd_ready, digit_idx} !==
                    {e.an, e.seg, e.fd, e.rdy, e.idx}) begin
                    failures++;
                    $display("FAIL out_p%0d t=%0t: got an_n=%b seg_n=%b fd=%b rdy=%b idx=%0d, want an_n=%b seg_n=%b fd=%b rdy=%b idx=%0d",
                             e.ph, $time, an_n, seg_n, frame_done, upd_ready, digit_idx,
                             e.an, e.seg, e.fd, e.rdy, e.idx);
                end
            end
        end
    end

    function automatic logic [3:0] an_sel(input int k);
        logic [3:0] a;
        a = 4'hF;
        a[k] = 1'b0;
        return a;
    endfunction

    task automatic push(input int ph, input logic [3:0] an, input logic [6:0] seg,
                        input logic fd, input logic rdy, input int idx);
        exp_t e;
        e.ph = ph; e.an = an; e.seg = seg; e.fd = fd; e.rdy = rdy; e.idx = 2'(idx);
        q.push_back(e);
    endtask

    task automatic cyc(input int ph, input logic [3:0] an, input logic [6:0] seg,
                       input logic fd, input logic rdy, input int idx);
        push(ph, an, seg, fd, rdy, idx);
        @(negedge clk);
    endtask

    // Two blank cycles, then four lit cycles of digit k.
    task automatic digit(input int ph, input int k, input logic [6:0] seg, input logic fd0,
                         input logic rb0, input logic rb1, input logic rs);
        cyc(ph, 4'hF, BL, fd0, rb0, k);
        cyc(ph, 4'hF, BL, 1'b0, rb1, k);
        repeat (4) cyc(ph, an_sel(k), seg, 1'b0, rs, k);
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; upd_valid = 1'b0; upd_data = 16'h0000;

        // Reset and idle
        repeat (2) cyc(1, 4'hF, BL, 1'b0, 1'b1, 0);
        rst_n = 1'b1;
        repeat (3) cyc(1, 4'hF, BL, 1'b0, 1'b1, 0);

        // Load 12AF while dark, then scan one frame
        upd_valid = 1'b1; upd_data = 16'h12AF;
        cyc(2, 4'hF, BL, 1'b0, 1'b0, 0);
        upd_valid = 1'b0;
        cyc(2, 4'hF, BL, 1'b0, 1'b1, 0);
        enable = 1'b1;
        digit(3, 0, PF, 1'b0, 1'b1, 1'b1, 1'b1);
        digit(3, 1, PA, 1'b0, 1'b1, 1'b1, 1'b1);
        upd_valid = 1'b1; upd_data = 16'h3333;
        digit(3, 2, P2, 1'b0, 1'b0, 1'b0, 1'b0);
        upd_data = 16'h4444;
        digit(3, 3, P1, 1'b0, 1'b0, 1'b0, 1'b0);

        // 3333 committed at frame_done; stalled 4444 accepted on the following edge
        digit(4, 0, P3, 1'b1, 1'b1, 1'b0, 1'b0);
        upd_valid = 1'b0;
        digit(4, 1, P3, 1'b0, 1'b0, 1'b0, 1'b0);
        digit(4, 2, P3, 1'b0, 1'b0, 1'b0, 1'b0);
        digit(4, 3, P3, 1'b0, 1'b0, 1'b0, 1'b0);

        // 4444 frame, enable dropped mid-SHOW at digit 2
        digit(5, 0, P4, 1'b1, 1'b1, 1'b1, 1'b1);
        digit(5, 1, P4, 1'b0, 1'b1, 1'b1, 1'b1);
        repeat (2) cyc(5, 4'hF, BL, 1'b0, 1'b1, 2);
        repeat (2) cyc(5, 4'b1011, P4, 1'b0, 1'b1, 2);
        enable = 1'b0;
        repeat (2) cyc(6, 4'hF, BL, 1'b0, 1'b1, 0);
        enable = 1'b1;
        digit(7, 0, P4, 1'b0, 1'b1, 1'b1, 1'b1);
        digit(7, 1, P4, 1'b0, 1'b1, 1'b1, 1'b1);
        digit(7, 2, P4, 1'b0, 1'b1, 1'b1, 1'b1);
        digit(7, 3, P4, 1'b0, 1'b1, 1'b1, 1'b1);
        cyc(7, 4'hF, BL, 1'b1, 1'b1, 0);
        enable = 1'b0;
        cyc(7, 4'hF, BL, 1'b0, 1'b1, 0);

        // Leading-zero frame 0050, plus a pending 8888 to be lost on reset
        upd_valid = 1'b1; upd_data = 16'h0050;
        cyc(8, 4'hF, BL, 1'b0, 1'b0, 0);
        upd_valid = 1'b0;
        cyc(8, 4'hF, BL, 1'b0, 1'b1, 0);
        enable = 1'b1;
        digit(9, 0, P0, 1'b0, 1'b1, 1'b1, 1'b1);
        upd_valid = 1'b1; upd_data = 16'h8888;
        digit(9, 1, P5, 1'b0, 1'b0, 1'b0, 1'b0);
        upd_valid = 1'b0;
        digit(9, 2, LZ, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) cyc(9, 4'hF, BL, 1'b0, 1'b0, 3);
        repeat (2) cyc(9, 4'b0111, LZ, 1'b0, 1'b0, 3);

        // Asynchronous reset mid-SHOW, sampled before the next clock edge
        push(10, 4'hF, BL, 1'b0, 1'b1, 0);
        #1 rst_n = 1'b0; enable = 1'b0;
        #1 probe = 1'b1;
        #2 probe = 1'b0;
        @(negedge clk);
        cyc(10, 4'hF, BL, 1'b0, 1'b1, 0);
        rst_n = 1'b1;
        cyc(10, 4'hF, BL, 1'b0, 1'b1, 0);
        enable = 1'b1;
        digit(11, 0, P0, 1'b0, 1'b1, 1'b1, 1'b1);
        digit(11, 1, LZ, 1'b0, 1'b1, 1'b1, 1'b1);
        digit(11, 2, LZ, 1'b0, 1'b1, 1'b1, 1'b1);
        digit(11, 3, LZ, 1'b0, 1'b1, 1'b1, 1'b1);
        cyc(11, 4'hF, BL, 1'b1, 1'b1, 0);

        repeat (2) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
